uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-fed UART transmitter, LSB first, idle-high line, oversampled bit timer.
// Optional macro UART_TX_PARITY_EN adds a parity bit and the i_parity_odd select input.
module uart_tx_fifo #(
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned STOP_BITS     = 2,
   parameter int unsigned COOLDOWN_BITS = 3,
   parameter int unsigned OSR           = 16,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                          divided_clk,
   input  logic                          i_rst,
   input  logic                          i_en,
`ifdef UART_TX_PARITY_EN
   input  logic                          i_parity_odd,
`endif
   input  logic [DATA_BITS-1:0]          i_data,
   input  logic                          i_valid,
   output logic                          o_ready,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned TW = $clog2(OSR);
   localparam int unsigned BW = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP,
      COOLDOWN
   } state_t;

   state_t               state, state_n;
   logic [TW-1:0]        tick, tick_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic [PW-1:0]        rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
   logic [CW-1:0]        count, count_n;
   logic                 tx_n, ready_n, busy_n;
   logic                 push, pop, can_pop, tick_last;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_n;
`endif

   assign push      = i_valid && o_ready;
   assign tick_last = (tick == TW'(OSR - 1));
   assign o_count   = count;

   // FIFO storage; no reset needed, occupancy lives in count
   always_ff @(posedge divided_clk) begin
      if (push) mem[wr_ptr] <= i_data;
   end

   // State and output registers
   always_ff @(posedge divided_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         tick    <= '0;
         bit_cnt <= '0;
         sh      <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         o_tx    <= 1'b1;
         o_ready <= 1'b1;
         o_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         tick    <= tick_n;
         bit_cnt <= bit_n;
         sh      <= sh_n;
         rd_ptr  <= rd_ptr_n;
         wr_ptr  <= wr_ptr_n;
         count   <= count_n;
         o_tx    <= tx_n;
         o_ready <= ready_n;
         o_busy  <= busy_n;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_n;
`endif
      end
   end

   // Next-state, bit timing and FIFO bookkeeping
   always_comb begin
      state_n = state;
      tick_n  = tick;
      bit_n   = bit_cnt;
      sh_n    = sh;
      tx_n    = o_tx;
      pop     = 1'b0;
      can_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = par_q;
`endif

      if (state != IDLE) tick_n = tick_last ? '0 : TW'(tick + TW'(1));

      case (state)
         IDLE: begin
            tx_n    = 1'b1;
            can_pop = 1'b1;
         end
         START: begin
            if (tick_last) begin
               state_n = DATA;
               bit_n   = '0;
               tx_n    = sh[0];
            end
         end
         DATA: begin
            if (tick_last) begin
               if (bit_cnt == BW'(DATA_BITS - 1)) begin
                  bit_n = '0;
`ifdef UART_TX_PARITY_EN
                  state_n = PARITY;
                  tx_n    = par_q;
`else
                  state_n = STOP;
                  tx_n    = 1'b1;
`endif
               end else begin
                  sh_n  = sh >> 1;
                  tx_n  = sh[1];
                  bit_n = BW'(bit_cnt + BW'(1));
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick_last) begin
               state_n = STOP;
               bit_n   = '0;
               tx_n    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick_last) begin
               if (bit_cnt == BW'(STOP_BITS - 1)) begin
                  bit_n = '0;
                  if (COOLDOWN_BITS == 0) begin
                     state_n = IDLE;
                     can_pop = 1'b1;
                  end else begin
                     state_n = COOLDOWN;
                  end
               end else begin
                  bit_n = BW'(bit_cnt + BW'(1));
               end
            end
         end
         COOLDOWN: begin
            if (tick_last) begin
               if (bit_cnt == BW'(COOLDOWN_BITS - 1)) begin
                  bit_n   = '0;
                  state_n = IDLE;
                  can_pop = 1'b1;
               end else begin
                  bit_n = BW'(bit_cnt + BW'(1));
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase

      // Pop straight into START so consecutive frames leave no idle gap
      if (can_pop && i_en && (count != '0)) begin
         pop     = 1'b1;
         state_n = START;
         tick_n  = '0;
         bit_n   = '0;
         sh_n    = mem[rd_ptr];
         tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_n   = (^mem[rd_ptr]) ^ i_parity_odd;
`endif
      end

      rd_ptr_n = pop  ? PW'(rd_ptr + PW'(1)) : rd_ptr;
      wr_ptr_n = push ? PW'(wr_ptr + PW'(1)) : wr_ptr;
      count_n  = CW'(count + CW'(push) - CW'(pop));
      ready_n  = (count_n < CW'(FIFO_DEPTH));
      busy_n   = (state_n != IDLE) || (count_n != '0);
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a scoreboard and a line monitor for uart_tx_fifo.
// Builds with or without UART_TX_PARITY_EN.
module tb_uart_tx_fifo;

   localparam int unsigned DB  = 8;
   localparam int unsigned SB  = 2;
   localparam int unsigned CB  = 3;
   localparam int unsigned OSR = 4;
   localparam int unsigned FD  = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned P   = 1;
`else
   localparam int unsigned P   = 0;
`endif
   localparam int unsigned NB  = 1 + DB + P + SB + CB;
   localparam int unsigned FL  = NB * OSR;
   localparam int unsigned CW  = $clog2(FD) + 1;

   logic          divided_clk = 1'b0;
   logic          i_rst, i_en, i_valid, i_parity_odd;
   logic [DB-1:0] i_data;
   logic          o_ready, o_tx, o_busy;
   logic [CW-1:0] o_count;

   int            errors = 0;
   int            checks = 0;
   int            frames = 0;
   int unsigned   cyc    = 0;
   logic [DB:0]   sb [$];
   int unsigned   starts [$];

   uart_tx_fifo #(
      .DATA_BITS(DB), .STOP_BITS(SB), .COOLDOWN_BITS(CB), .OSR(OSR), .FIFO_DEPTH(FD)
   ) dut (
      .divided_clk (divided_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
`ifdef UART_TX_PARITY_EN
      .i_parity_odd(i_parity_odd),
`endif
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_tx        (o_tx),
      .o_busy      (o_busy),
      .o_count     (o_count)
   );

   always #5 divided_clk = ~divided_clk;
   always @(posedge divided_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tmo(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed=timeout expected=event", tag);
   endtask

   // Expected line level for every cycle of one frame of word e = {odd, data}
   function automatic logic [63:0] frame_of(input logic [DB:0] e);
      logic [NB-1:0] b;
      logic [63:0]   f;
      b    = '1;
      b[0] = 1'b0;
      for (int k = 0; k < int'(DB); k++) b[1+k] = e[k];
      if (P == 1) b[1+DB] = (^e[DB-1:0]) ^ e[DB];
      f = '0;
      for (int i = 0; i < int'(FL); i++) f[i] = b[i/int'(OSR)];
      return f;
   endfunction

   task automatic push(input logic [DB-1:0] d);
      int t = 0;
      while (o_ready !== 1'b1 && t < 5000) begin @(posedge divided_clk); #1; t++; end
      if (t >= 5000) tmo("push_ready");
      i_valid = 1'b1;
      i_data  = d;
      @(posedge divided_clk);
      sb.push_back({i_parity_odd, d});
      #1 i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (o_busy !== 1'b0 && t < 5000) begin @(posedge divided_clk); #1; t++; end
      if (t >= 5000) tmo(tag);
   endtask

   // Called right after push() into an empty FIFO: start-bit latency and total busy length
   task automatic frame_len(input string tag);
      int c = 0;
      @(posedge divided_clk); #1;
      chk({tag, "_start"}, 64'(o_tx), 64'(0));
      while (o_busy !== 1'b0 && c < 5000) begin @(posedge divided_clk); #1; c++; end
      chk({tag, "_len"}, 64'(c), 64'(FL));
   endtask

   task automatic wait_frames(input int n, input string tag);
      int t = 0;
      while (frames < n && t < 5000) begin @(posedge divided_clk); #1; t++; end
      if (t >= 5000) tmo(tag);
   endtask

   // Line monitor: captures each frame cycle by cycle and scores it against the queue head
   initial begin
      logic [63:0] line;
      logic [DB:0] e;
      int unsigned st;
      bit          aborted;
      forever begin
         @(negedge divided_clk);
         if (i_rst === 1'b0 && o_tx === 1'b0) begin
            st      = cyc;
            line    = '0;
            aborted = 1'b0;
            for (int i = 0; i < int'(FL); i++) begin
               if (i > 0) @(negedge divided_clk);
               if (i_rst !== 1'b0) begin aborted = 1'b1; break; end
               line[i] = o_tx;
            end
            if (!aborted) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL unexpected_frame: observed=%0h expected=none", line);
               end else begin
                  e = sb.pop_front();
                  chk("frame", line, frame_of(e));
               end
               starts.push_back(st);
               frames++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DB-1:0] words [8];
      int f0, idx;
      words = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h5A, 8'h7E};

      i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b0; i_data = '0; i_parity_odd = 1'b0;
      repeat (3) @(posedge divided_clk);
      #1;
      chk("rst_tx",    64'(o_tx),    64'(1));
      chk("rst_ready", 64'(o_ready), 64'(1));
      chk("rst_busy",  64'(o_busy),  64'(0));
      chk("rst_count", 64'(o_count), 64'(0));
      i_rst = 1'b0;
      @(posedge divided_clk); #1;

      // Single word: edge N+1 latency and full frame length
      push(8'hA5);
      chk("lat_tx_n",  64'(o_tx),    64'(1));
      chk("lat_count", 64'(o_count), 64'(1));
      chk("lat_busy",  64'(o_busy),  64'(1));
      frame_len("a5");
      chk("a5_frames", 64'(frames), 64'(1));

      // Fill the FIFO with transmission disabled, then release
      i_en = 1'b0;
      for (int k = 0; k < 4; k++) push(words[k] ^ 8'h96);
      chk("full_ready", 64'(o_ready), 64'(0));
      chk("full_count", 64'(o_count), 64'(4));
      repeat (20) @(posedge divided_clk);
      #1;
      chk("held_tx",     64'(o_tx),   64'(1));
      chk("held_frames", 64'(frames), 64'(1));
      idx  = starts.size();
      i_en = 1'b1;
      wait_idle("burst_idle");
      chk("burst_frames", 64'(frames), 64'(5));
      if (starts.size() >= idx + 4) begin
         for (int k = 1; k < 4; k++)
            chk("burst_gap", 64'(starts[idx+k] - starts[idx+k-1]), 64'(FL));
      end else tmo("burst_starts");

      // Push and pop on the same edge at count 2, then stream through pointer wrap
      i_en = 1'b0;
      push(words[0]);
      push(words[1]);
      chk("pp_pre_count", 64'(o_count), 64'(2));
      i_en    = 1'b1;
      i_valid = 1'b1;
      i_data  = words[2];
      @(posedge divided_clk);
      sb.push_back({i_parity_odd, words[2]});
      #1 i_valid = 1'b0;
      chk("pp_count", 64'(o_count), 64'(2));
      chk("pp_tx",    64'(o_tx),    64'(0));
      for (int k = 3; k < 8; k++) push(words[k]);
      wait_idle("stream_idle");
      chk("stream_frames", 64'(frames), 64'(13));

      // Reset during data bit 3 of 0x3C with another word queued
      push(8'h3C);
      push(8'h99);
      repeat (17) @(posedge divided_clk);
      #1;
      i_rst = 1'b1;
      #1;
      chk("mid_rst_tx",    64'(o_tx),    64'(1));
      chk("mid_rst_count", 64'(o_count), 64'(0));
      chk("mid_rst_ready", 64'(o_ready), 64'(1));
      chk("mid_rst_busy",  64'(o_busy),  64'(0));
      sb.delete();
      repeat (2) @(posedge divided_clk);
      #1 i_rst = 1'b0;
      @(posedge divided_clk); #1;

      // Reset during a start bit must raise the line at once
      push(8'h00);
      @(posedge divided_clk); #1;
      i_rst = 1'b1;
      #1;
      chk("start_rst_tx", 64'(o_tx), 64'(1));
      sb.delete();
      repeat (2) @(posedge divided_clk);
      #1 i_rst = 1'b0;
      @(posedge divided_clk); #1;
      push(8'h55);
      frame_len("post_rst");
      chk("post_rst_frames", 64'(frames), 64'(14));
      f0 = frames;

`ifdef UART_TX_PARITY_EN
      i_parity_odd = 1'b0;
      push(8'hA5);
      frame_len("par_even");
      i_parity_odd = 1'b1;
      push(8'hA5);
      frame_len("par_odd");
      i_parity_odd = 1'b0;
      chk("par_frames", 64'(frames), 64'(f0 + 2));
      f0 = frames;
`endif

      // Drop i_en mid-frame: current frame finishes, queued word waits
      push(8'h96);
      push(8'h69);
      repeat (10) @(posedge divided_clk);
      #1 i_en = 1'b0;
      wait_frames(f0 + 1, "en_frame");
      repeat (8) @(posedge divided_clk);
      #1;
      chk("en_hold_tx",     64'(o_tx),    64'(1));
      chk("en_hold_count",  64'(o_count), 64'(1));
      chk("en_hold_busy",   64'(o_busy),  64'(1));
      chk("en_hold_frames", 64'(frames),  64'(f0 + 1));
      i_en = 1'b1;
      @(posedge divided_clk); #1;
      chk("en_restart_tx", 64'(o_tx), 64'(0));
      wait_idle("en_idle");
      chk("en_frames", 64'(frames), 64'(f0 + 2));

      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
